rt_sphere_worker: RTL and testbench
===================================

RT_SPHERE_WORKER -- requirements
Module: rt_sphere_worker

Interface
REQ-001 SHALL have parameter JOBS, default 8, meaning pixels processed per start.
REQ-002 SHALL have parameter X_STRIDE, default 4, meaning x increment between consecutive pixels (worker count).
REQ-003 SHALL have parameter N_SPHERES, default 4, meaning spheres tested per pixel (>=1).
REQ-004 SHALL have parameter CW, default 12, meaning signed coordinate width.
REQ-005 SHALL have parameter PZ, default 320, meaning constant ray z component.
REQ-006 SHALL have parameter BG_COLOR, default 12'h000, meaning miss color.
REQ-007 SHALL have parameter SHADE_SHIFT, default 10, meaning depth-shading scale.
REQ-008 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-009 SHALL have port rst_  in  1  asynchronous active-low reset.
REQ-010 SHALL have ports start in 1 (job request), pixel_start_x in CW signed, and pixel_y in CW signed; all three are sampled when start is accepted.
REQ-011 SHALL have port busy  out  1  high from accepted start until done.
REQ-012 SHALL have ports sph_idx out clog2(N_SPHERES) (table address), sph_x/sph_y/sph_z in CW signed (centre), sph_r in CW unsigned (radius), and sph_color in 12 (RGB444).
REQ-013 SHALL have ports pix_valid out 1, pix_ready in 1, pix_color out 12, and pix_x out CW signed, forming the result stream.
REQ-014 SHALL have port done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-015 SHALL have FSM states IDLE, FETCH, SETUP, DISC, SQRT, COMPARE, EMIT, DONE.
REQ-016 IDLE SHALL accept start only when not busy; start while busy SHALL be ignored.
REQ-017 Pixel j (0..JOBS-1) SHALL have x = pixel_start_x + j*X_STRIDE, computed modulo 2^CW.
REQ-018 FETCH SHALL drive sph_idx = k; sphere inputs SHALL be sampled on the following edge (one-cycle table latency).
REQ-019 SETUP/DISC SHALL compute exact integers with ray d=(x,pixel_y,PZ): a=d.d, b=2(d.s), c=s.s-r^2, disc=b^2-4ac, using internal width 4*CW+8 with no truncation.
REQ-020 SQRT SHALL be a bit-serial floor integer square root, one result bit per cycle, 2*CW+4 cycles, executed only when disc>=0.
REQ-021 When disc<0, the FSM SHALL skip SQRT and record no hit for sphere k.
REQ-022 COMPARE SHALL form t_num=b-isqrt(disc); a hit requires t_num>=0.
REQ-023 The nearest hit SHALL be the smallest t_num; on equal t_num the lower k SHALL be kept.
REQ-024 After sphere N_SPHERES-1, the FSM SHALL go to EMIT; otherwise it SHALL return to FETCH with k+1.
REQ-025 EMIT SHALL assert pix_valid with pix_x/pix_color; these SHALL be held stable while pix_ready is low.
REQ-026 A transfer SHALL occur on pix_valid&&pix_ready; the next cycle SHALL start pixel j+1 at FETCH, or go to DONE after pixel JOBS-1.
REQ-027 DONE SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-028 A pixel with no hit SHALL output BG_COLOR.

Reset
REQ-029 rst_ low SHALL immediately force IDLE, with busy=0, pix_valid=0, done=0, sph_idx=0, pix_color=0, pix_x=0, and internal job/sphere counters at 0.
REQ-030 Reset mid-operation SHALL abandon the job, emit no further pixels, and raise no done pulse.

Configuration
REQ-031 Macro RT_WORKER_SHADING_EN SHALL select the hit color: when defined, each 4-bit channel = channel >> min(3, t_num >> SHADE_SHIFT); when undefined, hit color = sph_color unmodified and the shading logic SHALL be absent.

Verification
REQ-032 Sphere (0,0,640) r=100, pixel_start_x=0, pixel_y=0, JOBS=1, no shading -> disc=4096000000, isqrt=64000, t_num=345600, pix_color=sph_color, pix_x=0.
REQ-033 Same sphere, pixel_start_x=300 -> disc<0, SQRT skipped, pix_color=BG_COLOR.
REQ-034 Sphere (0,0,-640) r=100, pixel (0,0) -> t_num=-473600, no hit, BG_COLOR.
REQ-035 Sphere0 (0,0,1280) color 12'hF00 and sphere1 (0,0,640) color 12'h0F0, r=100, pixel (0,0) -> pix_color=12'h0F0; two identical spheres -> the index-0 color is output.
REQ-036 JOBS=8, X_STRIDE=4, pixel_start_x=2044 (CW=12) -> pix_x sequence 2044,-2048,...,-2024 (wraps); pix_ready held low 5 cycles at pixel 3 -> outputs stable; exactly 8 transfers, then a done pulse.
REQ-037 rst_ low during SQRT of pixel 2 -> busy=0, pix_valid=0 asynchronously, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/rt_sphere_worker_if.sv
// Bundle of the job-request, sphere-table and pixel-stream signals of rt_sphere_worker.
// The worker connects through the slave modport; the job issuer / table / sink through master.
interface rt_sphere_worker_if #(
    parameter int CW        = 12,
    parameter int N_SPHERES = 4
);
    localparam int IW = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;

    logic                 start;
    logic signed [CW-1:0] pixel_start_x;
    logic signed [CW-1:0] pixel_y;
    logic                 busy;
    logic                 done;

    logic [IW-1:0]        sph_idx;
    logic signed [CW-1:0] sph_x;
    logic signed [CW-1:0] sph_y;
    logic signed [CW-1:0] sph_z;
    logic [CW-1:0]        sph_r;
    logic [11:0]          sph_color;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [11:0]          pix_color;
    logic signed [CW-1:0] pix_x;

    modport master (
        output start, pixel_start_x, pixel_y,
        output sph_x, sph_y, sph_z, sph_r, sph_color,
        output pix_ready,
        input  busy, done, sph_idx, pix_valid, pix_color, pix_x
    );

    modport slave (
        input  start, pixel_start_x, pixel_y,
        input  sph_x, sph_y, sph_z, sph_r, sph_color,
        input  pix_ready,
        output busy, done, sph_idx, pix_valid, pix_color, pix_x
    );
endinterface

// File: rtl/rt_sphere_worker.sv
// Ray/sphere intersection worker: renders JOBS pixels of one row per start, nearest hit wins.
// Optional depth shading of the hit colour is enabled by defining RT_WORKER_SHADING_EN.
module rt_sphere_worker #(
    parameter int          JOBS        = 8,
    parameter int          X_STRIDE    = 4,
    parameter int          N_SPHERES   = 4,
    parameter int          CW          = 12,
    parameter int          PZ          = 320,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter int          SHADE_SHIFT = 10
) (
    input  logic                clk,
    input  logic                rst_,
    rt_sphere_worker_if.slave   bus
);
    localparam int W    = 4*CW + 8;    // exact width for b^2 - 4ac
    localparam int QW   = 2*CW + 4;    // square-root result bits, one per SQRT cycle
    localparam int RW   = QW + 2;      // partial remainder
    localparam int IW   = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
    localparam int JW   = (JOBS > 1) ? $clog2(JOBS) : 1;
    localparam int CNTW = $clog2(QW);
    localparam logic signed [W-1:0] PZ_W = W'(PZ);

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, DISC, SQRT, COMPARE, EMIT, DONE} state_t;

    state_t state, state_nxt;

    logic [IW-1:0]        k;
    logic [JW-1:0]        j;
    logic signed [CW-1:0] cur_x, y_q;
    logic signed [W-1:0]  a_q, b_q, c_q;
    logic [11:0]          color_q;
    logic                 disc_neg;
    logic [W-1:0]         rad;
    logic [RW-1:0]        rem;
    logic [QW-1:0]        root;
    logic [CNTW-1:0]      sqrt_cnt;
    logic                 best_valid;
    logic signed [W-1:0]  best_t;
    logic [11:0]          best_color;

    logic signed [W-1:0]  x_w, y_w, sx_w, sy_w, sz_w, r_w;
    logic signed [W-1:0]  a_c, b_c, c_c, disc_c, t_num;
    logic [RW+1:0]        rem_sh, trial;
    logic                 root_bit, hit, last_sph, last_job, xfer;
    logic [11:0]          hit_color;

    // Sphere-table data is valid in SETUP (sph_idx has been stable since FETCH).
    always_comb begin
        x_w  = W'(cur_x);
        y_w  = W'(y_q);
        sx_w = W'(bus.sph_x);
        sy_w = W'(bus.sph_y);
        sz_w = W'(bus.sph_z);
        r_w  = W'(bus.sph_r);
        a_c  = x_w*x_w + y_w*y_w + PZ_W*PZ_W;
        b_c  = (x_w*sx_w + y_w*sy_w + PZ_W*sz_w) <<< 1;
        c_c  = sx_w*sx_w + sy_w*sy_w + sz_w*sz_w - r_w*r_w;
        disc_c = b_q*b_q - ((a_q*c_q) <<< 2);
        t_num  = b_q - $signed(W'(root));
    end

    // Digit-by-digit square root: two radicand bits in, one root bit out per cycle.
    always_comb begin
        rem_sh   = {rem, rad[W-1 -: 2]};
        trial    = {2'b00, root, 2'b01};
        root_bit = (rem_sh >= trial);
    end

    always_comb begin
        hit      = !disc_neg && !t_num[W-1];
        last_sph = (k == IW'(N_SPHERES - 1));
        last_job = (j == JW'(JOBS - 1));
        xfer     = (state == EMIT) && bus.pix_ready;
    end

`ifdef RT_WORKER_SHADING_EN
    logic [W-1:0] shade_lvl;
    logic [1:0]   shade_amt;

    always_comb begin
        shade_lvl = W'(t_num) >> SHADE_SHIFT;
        shade_amt = (shade_lvl > W'(3)) ? 2'd3 : shade_lvl[1:0];
        hit_color = {color_q[11:8] >> shade_amt, color_q[7:4] >> shade_amt,
                     color_q[3:0] >> shade_amt};
    end
`else
    assign hit_color = color_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = SETUP;
            SETUP:   state_nxt = DISC;
            DISC:    state_nxt = disc_c[W-1] ? COMPARE : SQRT;
            SQRT:    if (sqrt_cnt == CNTW'(QW - 1)) state_nxt = COMPARE;
            COMPARE: state_nxt = last_sph ? EMIT : FETCH;
            EMIT:    if (bus.pix_ready) state_nxt = last_job ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE) && (state != DONE);
        bus.done      = (state == DONE);
        bus.pix_valid = (state == EMIT);
        bus.pix_x     = '0;
        bus.pix_color = '0;
        bus.sph_idx   = k;
        if (state == EMIT) begin
            bus.pix_x     = cur_x;
            bus.pix_color = best_valid ? best_color : BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            k          <= '0;
            j          <= '0;
            cur_x      <= '0;
            y_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            color_q    <= '0;
            disc_neg   <= 1'b1;
            rad        <= '0;
            rem        <= '0;
            root       <= '0;
            sqrt_cnt   <= '0;
            best_valid <= 1'b0;
            best_t     <= '0;
            best_color <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    cur_x      <= bus.pixel_start_x;
                    y_q        <= bus.pixel_y;
                    j          <= '0;
                    k          <= '0;
                    best_valid <= 1'b0;
                end
                SETUP: begin
                    a_q     <= a_c;
                    b_q     <= b_c;
                    c_q     <= c_c;
                    color_q <= bus.sph_color;
                end
                DISC: begin
                    disc_neg <= disc_c[W-1];
                    rad      <= disc_c;
                    rem      <= '0;
                    root     <= '0;
                    sqrt_cnt <= '0;
                end
                SQRT: begin
                    rad      <= {rad[W-3:0], 2'b00};
                    rem      <= root_bit ? RW'(rem_sh - trial) : RW'(rem_sh);
                    root     <= {root[QW-2:0], root_bit};
                    sqrt_cnt <= sqrt_cnt + 1'b1;
                end
                COMPARE: begin
                    // Strict less-than keeps the lower sphere index on equal depth.
                    if (hit && (!best_valid || t_num < best_t)) begin
                        best_valid <= 1'b1;
                        best_t     <= t_num;
                        best_color <= hit_color;
                    end
                    k <= last_sph ? '0 : k + 1'b1;
                end
                EMIT: if (xfer) begin
                    best_valid <= 1'b0;
                    if (!last_job) begin
                        j     <= j + 1'b1;
                        cur_x <= cur_x + CW'(X_STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rt_sphere_worker.sv
// Scoreboard bench for rt_sphere_worker: a reference model pushes expected pixels per job,
// the output stream pops and compares them; reset, stall, wrap and abort scenarios.
module tb_rt_sphere_worker;
    localparam int          CW          = 12;
    localparam int          JOBS        = 8;
    localparam int          X_STRIDE    = 4;
    localparam int          N_SPHERES   = 4;
    localparam int          PZ          = 320;
    localparam logic [11:0] BG          = 12'h000;
    localparam int          SHADE_SHIFT = 10;
    localparam int          BUDGET      = 5000;

    typedef struct {
        logic signed [CW-1:0] x;
        logic [11:0]          color;
    } pix_t;

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk = ~clk;

    rt_sphere_worker_if #(.CW(CW), .N_SPHERES(N_SPHERES)) bus ();

    rt_sphere_worker #(
        .JOBS(JOBS), .X_STRIDE(X_STRIDE), .N_SPHERES(N_SPHERES), .CW(CW),
        .PZ(PZ), .BG_COLOR(BG), .SHADE_SHIFT(SHADE_SHIFT)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    logic signed [CW-1:0] tx [N_SPHERES];
    logic signed [CW-1:0] ty [N_SPHERES];
    logic signed [CW-1:0] tz [N_SPHERES];
    logic [CW-1:0]        tr [N_SPHERES];
    logic [11:0]          tc [N_SPHERES];

    // Sphere table with one cycle of read latency.
    always @(posedge clk) begin
        bus.sph_x     <= tx[bus.sph_idx];
        bus.sph_y     <= ty[bus.sph_idx];
        bus.sph_z     <= tz[bus.sph_idx];
        bus.sph_r     <= tr[bus.sph_idx];
        bus.sph_color <= tc[bus.sph_idx];
    end

    pix_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic longint isqrt_model(input longint d);
        longint r;
        r = longint'($sqrt(real'(d)));
        while (r * r > d) r--;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
    endfunction

    function automatic logic [11:0] model_color(input longint px, input longint py);
        longint      sx, sy, sz, r, a, b, c, d, t, best, lvl;
        bit          found;
        logic [11:0] col;
        int          amt;
        found = 1'b0;
        best  = 0;
        col   = BG;
        for (int i = 0; i < N_SPHERES; i++) begin
            sx = longint'(tx[i]);
            sy = longint'(ty[i]);
            sz = longint'(tz[i]);
            r  = longint'(tr[i]);
            a  = px*px + py*py + PZ*PZ;
            b  = 2 * (px*sx + py*sy + PZ*sz);
            c  = sx*sx + sy*sy + sz*sz - r*r;
            d  = b*b - 4*a*c;
            if (d >= 0) begin
                t = b - isqrt_model(d);
                if (t >= 0 && (!found || t < best)) begin
                    found = 1'b1;
                    best  = t;
`ifdef RT_WORKER_SHADING_EN
                    lvl = t >>> SHADE_SHIFT;
                    amt = (lvl > 3) ? 3 : int'(lvl);
                    col = {tc[i][11:8] >> amt, tc[i][7:4] >> amt, tc[i][3:0] >> amt};
`else
                    lvl = 0;
                    amt = 0;
                    col = tc[i];
`endif
                end
            end
        end
        return col;
    endfunction

    task automatic set_sphere(input int i, input int x, input int y, input int z,
                              input int r, input logic [11:0] c);
        tx[i] = CW'(x);
        ty[i] = CW'(y);
        tz[i] = CW'(z);
        tr[i] = CW'(r);
        tc[i] = c;
    endtask

    // Spheres behind the camera never produce a hit.
    task automatic fill_miss();
        for (int i = 0; i < N_SPHERES; i++) set_sphere(i, 0, 0, -640, 100, 12'hFFF);
    endtask

    // One full job: expectations pushed up front, popped as pixels are accepted.
    task automatic run_job(input string name, input int sx, input int py, input int stall_pix,
                           input bit poke, output logic [11:0] first_color);
        pix_t                 e;
        logic signed [CW-1:0] xx;
        logic signed [CW-1:0] yy;
        int got, extra, stall_left, done_cnt, cyc, tail;
        got = 0; extra = 0; stall_left = 5; done_cnt = 0; cyc = 0; tail = 0;
        first_color = 12'hxxx;
        sb.delete();
        yy = CW'(py);
        for (int jj = 0; jj < JOBS; jj++) begin
            xx      = CW'(sx + jj * X_STRIDE);
            e.x     = xx;
            e.color = model_color(longint'(xx), longint'(yy));
            sb.push_back(e);
        end
        @(negedge clk);
        bus.pixel_start_x = CW'(sx);
        bus.pixel_y       = yy;
        bus.start         = 1'b1;
        bus.pix_ready     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b, expected 1", name, bus.busy);
        end
        while (cyc < BUDGET && tail < 4) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 30) begin
                bus.pixel_start_x = CW'(100);
                bus.start         = 1'b1;
            end
            if (poke && cyc == 31) bus.start = 1'b0;
            if (bus.done) done_cnt++;
            if (got == JOBS) begin
                tail++;
                if (bus.pix_valid) extra++;
            end else if (bus.pix_valid) begin
                n_tests++;
                if (bus.pix_x !== sb[0].x || bus.pix_color !== sb[0].color) begin
                    n_fail++;
                    $display("FAIL %s pixel%0d%s: got x=%0d color=%h, expected x=%0d color=%h",
                             name, got, (got == stall_pix && stall_left > 0) ? "_stalled" : "",
                             bus.pix_x, bus.pix_color, sb[0].x, sb[0].color);
                end
                if (got == stall_pix && stall_left > 0) begin
                    bus.pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.pix_ready = 1'b1;
                    if (got == 0) first_color = bus.pix_color;
                    void'(sb.pop_front());
                    got++;
                end
            end
        end
        n_tests++;
        if (got + extra !== JOBS) begin
            n_fail++;
            $display("FAIL %s transfers: got %0d, expected %0d (cycles %0d)", name, got + extra, JOBS, cyc);
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_done: got %b, expected 0", name, bus.busy);
        end
    endtask

    task automatic check_color(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got color %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #2 rst_ = 1'b0;
        #4;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.sph_idx !== '0 || bus.pix_color !== 12'h000 || bus.pix_x !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b idx=%0d color=%h x=%0d, expected all 0",
                     bus.busy, bus.pix_valid, bus.done, bus.sph_idx, bus.pix_color, bus.pix_x);
        end
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", bus.busy, bus.pix_valid);
        end
    endtask

    task automatic test_single_hit();
        logic [11:0] fc;
        fill_miss();
        set_sphere(0, 0, 0, 640, 100, 12'hABC);
        run_job("single_hit", 0, 0, -1, 1'b0, fc);
        check_color("single_hit_pixel0", fc, 12'hABC);
    endtask

    task automatic test_disc_negative();
        logic [11:0] fc;
        fill_miss();
        set_sphere(0, 0, 0, 640, 100, 12'hABC);
        run_job("disc_negative", 300, 0, -1, 1'b0, fc);
        check_color("disc_negative_pixel0", fc, BG);
    endtask

    task automatic test_behind();
        logic [11:0] fc;
        fill_miss();
        set_sphere(0, 0, 0, -640, 100, 12'h3C3);
        run_job("behind", 0, 0, -1, 1'b0, fc);
        check_color("behind_pixel0", fc, BG);
    endtask

    task automatic test_nearest();
        logic [11:0] fc;
        fill_miss();
        set_sphere(0, 0, 0, 1280, 100, 12'hF00);
        set_sphere(1, 0, 0, 640, 100, 12'h0F0);
        run_job("nearest", 0, 0, -1, 1'b0, fc);
        check_color("nearest_pixel0", fc, 12'h0F0);
        fill_miss();
        set_sphere(0, 0, 0, 640, 100, 12'h123);
        set_sphere(1, 0, 0, 640, 100, 12'h456);
        run_job("tie", 0, 0, -1, 1'b0, fc);
        check_color("tie_pixel0", fc, 12'h123);
    endtask

    task automatic test_wrap_stall();
        logic [11:0] fc;
        fill_miss();
        set_sphere(0, -2040, 0, 320, 200, 12'h0AF);
        set_sphere(1, 2040, 0, 320, 100, 12'hF0A);
        set_sphere(3, 0, -12, 640, 150, 12'h777);
        run_job("wrap_stall", 2044, -12, 3, 1'b1, fc);
    endtask

    task automatic test_reset_midop();
        logic [11:0] fc;
        int got, cyc, bad;
        got = 0; cyc = 0; bad = 0;
        fill_miss();
        set_sphere(0, 0, 0, 640, 100, 12'h5A5);
        @(negedge clk);
        bus.pixel_start_x = '0;
        bus.pixel_y       = '0;
        bus.start         = 1'b1;
        bus.pix_ready     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (got < 2 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (bus.pix_valid) got++;
        end
        n_tests++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL abort_reach_pixel2: got %0d pixels, expected 2", got);
        end
        // Pixel 2 then spends FETCH, SETUP, DISC and 28 cycles in SQRT on sphere 0.
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: got %b, expected 1", bus.busy);
        end
        #2 rst_ = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.done !== 1'b0 || bus.sph_idx !== '0) begin
            n_fail++;
            $display("FAIL abort_async_reset: got busy=%b valid=%b done=%b idx=%0d, expected 0 0 0 0",
                     bus.busy, bus.pix_valid, bus.done, bus.sph_idx);
        end
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus.done || bus.pix_valid || bus.busy) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, expected 0", bad);
        end
        run_job("after_abort", 0, 0, -1, 1'b0, fc);
        check_color("after_abort_pixel0", fc, 12'h5A5);
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.pixel_start_x = '0;
        bus.pixel_y       = '0;
        bus.pix_ready     = 1'b0;
        fill_miss();
        test_reset();
        test_single_hit();
        test_disc_negative();
        test_behind();
        test_nearest();
        test_wrap_stall();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
